// File: rtl/class_hv_accumulator.sv
// Purpose: per-dimension saturating accumulator that builds one DIMS_PER_CC chunk of a class HV.
// Latency: an accepted beat shows in class_hv_out/sample_count on the next cycle.
// Backpressure: hv_ready is high only in ACCUM; the result is held in DONE until acc_ready.
// Optional feature: define CLASS_ACC_RETRAIN_EN to add the hv_sub port (saturating subtract beats).
module class_hv_accumulator #(
  parameter int DIMS_PER_CC      = 1024,
  parameter int BITWIDTH_PER_DIM = 9,
  parameter int CNT_W            = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic                                             hv_valid,
  output logic                                             hv_ready,
  input  logic [DIMS_PER_CC-1:0]                           hv_in,
`ifdef CLASS_ACC_RETRAIN_EN
  input  logic                                             hv_sub,
`endif
  input  logic                                             finish,
  output logic                                             acc_valid,
  input  logic                                             acc_ready,
  output logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0]     class_hv_out,
  output logic [CNT_W-1:0]                                 sample_count,
  output logic                                             sat_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [BITWIDTH_PER_DIM-1:0] DIM_ZERO = '0;
  localparam logic [BITWIDTH_PER_DIM-1:0] DIM_MAX  = '1;
  localparam logic [BITWIDTH_PER_DIM-1:0] DIM_ONE  = {{(BITWIDTH_PER_DIM-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]            SMP_MAX  = '1;
  localparam logic [CNT_W-1:0]            SMP_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                                         state_q;
  state_t                                         state_nxt;
  logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0]   cnt_q;
  logic [DIMS_PER_CC-1:0][BITWIDTH_PER_DIM-1:0]   cnt_nxt;
  logic [CNT_W-1:0]                               smp_q;
  logic                                           sat_q;
  logic                                           sat_hit;
  logic                                           sub_beat;
  logic                                           accept;

`ifdef CLASS_ACC_RETRAIN_EN
  assign sub_beat = hv_sub;
`else
  assign sub_beat = 1'b0;
`endif

  // A beat only lands while accumulating; start in the same cycle discards it.
  assign accept = hv_valid && (state_q == ACCUM);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic: start overrides everything, then the per-state exits.
  always_comb begin
    state_nxt = state_q;
    if (start) begin
      state_nxt = ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_nxt = IDLE;
        ACCUM:   if (finish) state_nxt = DONE;
        DONE:    if (acc_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    hv_ready  = 1'b0;
    acc_valid = 1'b0;
    case (state_q)
      ACCUM:   hv_ready  = 1'b1;
      DONE:    acc_valid = 1'b1;
      default: begin
        hv_ready  = 1'b0;
        acc_valid = 1'b0;
      end
    endcase
  end

  // Per-dimension saturating step; sat_hit flags any counter pinned at a limit.
  always_comb begin
    cnt_nxt = cnt_q;
    sat_hit = 1'b0;
    for (int i = 0; i < DIMS_PER_CC; i++) begin
      if (hv_in[i]) begin
        if (sub_beat) begin
          if (cnt_q[i] == DIM_ZERO) begin
            sat_hit = 1'b1;
          end else begin
            cnt_nxt[i] = cnt_q[i] - DIM_ONE;
          end
        end else begin
          if (cnt_q[i] == DIM_MAX) begin
            sat_hit = 1'b1;
          end else begin
            cnt_nxt[i] = cnt_q[i] + DIM_ONE;
          end
        end
      end
    end
  end

  // Counter vector, sample count and sticky saturation flag; start clears them in any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      smp_q <= '0;
      sat_q <= 1'b0;
    end else if (start) begin
      cnt_q <= '0;
      smp_q <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_nxt;
      if (!sub_beat && (smp_q != SMP_MAX)) begin
        smp_q <= smp_q + SMP_ONE;
      end
      if (sat_hit) begin
        sat_q <= 1'b1;
      end
    end
  end

  assign class_hv_out = cnt_q;
  assign sample_count = smp_q;
  assign sat_flag     = sat_q;

endmodule

// File: tb/tb_class_hv_accumulator.sv
// Self-checking bench for class_hv_accumulator: a behavioural model predicts each result,
// which is queued when the stimulus is driven and compared when acc_valid is presented.
// Define CLASS_ACC_RETRAIN_EN for both files to also exercise subtract beats.
module tb_class_hv_accumulator;

  localparam int D  = 1024;
  localparam int BW = 9;
  localparam int CW = 16;

  typedef struct {
    logic [D-1:0][BW-1:0] hv;
    logic [CW-1:0]        cnt;
    logic                 sat;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 hv_valid;
  logic                 hv_ready;
  logic [D-1:0]         hv_in;
`ifdef CLASS_ACC_RETRAIN_EN
  logic                 hv_sub;
`endif
  logic                 finish;
  logic                 acc_valid;
  logic                 acc_ready;
  logic [D-1:0][BW-1:0] class_hv_out;
  logic [CW-1:0]        sample_count;
  logic                 sat_flag;

  int checks = 0;
  int errors = 0;

  exp_t sb[$];
  exp_t e;

  logic [D-1:0][BW-1:0] m_cnt;
  int unsigned          m_samples;
  logic                 m_sat;

  class_hv_accumulator #(.DIMS_PER_CC(D), .BITWIDTH_PER_DIM(BW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .hv_valid     (hv_valid),
    .hv_ready     (hv_ready),
    .hv_in        (hv_in),
`ifdef CLASS_ACC_RETRAIN_EN
    .hv_sub       (hv_sub),
`endif
    .finish       (finish),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .class_hv_out (class_hv_out),
    .sample_count (sample_count),
    .sat_flag     (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int first_diff(input logic [D-1:0][BW-1:0] a, input logic [D-1:0][BW-1:0] b);
    for (int i = 0; i < D; i++) begin
      if (a[i] !== b[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_cnt     = '0;
    m_samples = 0;
    m_sat     = 1'b0;
  endtask

  task automatic model_beat(input logic [D-1:0] v, input bit sub);
    for (int i = 0; i < D; i++) begin
      if (v[i]) begin
        if (sub) begin
          if (m_cnt[i] == 0) m_sat = 1'b1;
          else m_cnt[i] = m_cnt[i] - 1;
        end else begin
          if (m_cnt[i] == 511) m_sat = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (!sub && m_samples < 65535) m_samples++;
  endtask

  task automatic push_expected();
    exp_t x;
    x.hv  = m_cnt;
    x.cnt = m_samples[CW-1:0];
    x.sat = m_sat;
    sb.push_back(x);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  // Drives one beat that the DUT must accept (caller guarantees ACCUM).
  task automatic send_beat(input logic [D-1:0] v, input bit sub, input bit fin);
    hv_valid = 1'b1;
    hv_in    = v;
    finish   = fin;
`ifdef CLASS_ACC_RETRAIN_EN
    hv_sub   = sub;
`endif
    tick();
    hv_valid = 1'b0;
    finish   = 1'b0;
`ifdef CLASS_ACC_RETRAIN_EN
    hv_sub   = 1'b0;
`endif
    model_beat(v, sub);
  endtask

  task automatic close_accum();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic wait_acc(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (acc_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (5) tick();
    checks++; if (hv_ready !== 1'b0) begin errors++; $display("FAIL reset_hv_ready got=%b exp=0", hv_ready); end
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL reset_acc_valid got=%b exp=0", acc_valid); end
    checks++; if (class_hv_out !== '0) begin errors++; $display("FAIL reset_class_hv first nonzero dim=%0d", first_diff(class_hv_out, '0)); end
    checks++; if (sample_count !== '0) begin errors++; $display("FAIL reset_sample_count got=%0d exp=0", sample_count); end
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat_flag got=%b exp=0", sat_flag); end
  endtask

  task automatic test_basic();
    bit ok;
    int idx;
    do_start();
    checks++; if (hv_ready !== 1'b1) begin errors++; $display("FAIL basic_hv_ready got=%b exp=1", hv_ready); end
    repeat (3) send_beat('1, 1'b0, 1'b0);
    close_accum();
    push_expected();
    wait_acc(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_acc_valid_timeout got=%b exp=1", acc_valid); end
    repeat (4) begin
      tick();
      checks++; if (acc_valid !== 1'b1) begin errors++; $display("FAIL basic_acc_valid_hold got=%b exp=1", acc_valid); end
    end
    e = sb.pop_front();
    idx = first_diff(class_hv_out, e.hv);
    checks++; if (idx >= 0) begin errors++; $display("FAIL basic_class_hv dim=%0d got=%0d exp=%0d", idx, class_hv_out[idx], e.hv[idx]); end
    checks++; if (class_hv_out[D-1] !== 9'd3) begin errors++; $display("FAIL basic_top_dim got=%0d exp=3", class_hv_out[D-1]); end
    checks++; if (sample_count !== e.cnt) begin errors++; $display("FAIL basic_sample_count got=%0d exp=%0d", sample_count, e.cnt); end
    checks++; if (sat_flag !== e.sat) begin errors++; $display("FAIL basic_sat_flag got=%b exp=%b", sat_flag, e.sat); end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    checks++; if (acc_valid !== 1'b0) begin errors++; $display("FAIL basic_handoff_acc_valid got=%b exp=0", acc_valid); end
    checks++; if (hv_ready !== 1'b0) begin errors++; $display("FAIL basic_idle_hv_ready got=%b exp=0", hv_ready); end
    idx = first_diff(class_hv_out, e.hv);
    checks++; if (idx >= 0) begin errors++; $display("FAIL basic_idle_held dim=%0d got=%0d exp=%0d", idx, class_hv_out[idx], e.hv[idx]); end
  endtask

  task automatic test_saturation();
    bit ok;
    int idx;
    logic [D-1:0] v;
    v = '0;
    v[0] = 1'b1;
    do_start();
    repeat (600) send_beat(v, 1'b0, 1'b0);
    close_accum();
    push_expected();
    wait_acc(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_acc_valid_timeout got=%b exp=1", acc_valid); end
    e = sb.pop_front();
    idx = first_diff(class_hv_out, e.hv);
    checks++; if (idx >= 0) begin errors++; $display("FAIL sat_class_hv dim=%0d got=%0d exp=%0d", idx, class_hv_out[idx], e.hv[idx]); end
    checks++; if (class_hv_out[0] !== 9'd511) begin errors++; $display("FAIL sat_dim0 got=%0d exp=511", class_hv_out[0]); end
    checks++; if (sample_count !== 16'd600 || sample_count !== e.cnt) begin errors++; $display("FAIL sat_sample_count got=%0d exp=600", sample_count); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag got=%b exp=1", sat_flag); end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  task automatic test_beat_with_finish();
    bit ok;
    int idx;
    logic [D-1:0] v;
    v = '0;
    v[2:0] = 3'b101;
    do_start();
    send_beat(v, 1'b0, 1'b1);
    push_expected();
    // Beats offered in DONE must be ignored.
    repeat (3) begin
      hv_valid = 1'b1;
      hv_in    = '1;
      tick();
      checks++; if (hv_ready !== 1'b0) begin errors++; $display("FAIL bwf_hv_ready_done got=%b exp=0", hv_ready); end
    end
    hv_valid = 1'b0;
    wait_acc(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bwf_acc_valid_timeout got=%b exp=1", acc_valid); end
    e = sb.pop_front();
    idx = first_diff(class_hv_out, e.hv);
    checks++; if (idx >= 0) begin errors++; $display("FAIL bwf_class_hv dim=%0d got=%0d exp=%0d", idx, class_hv_out[idx], e.hv[idx]); end
    checks++; if (class_hv_out[0] !== 9'd1 || class_hv_out[1] !== 9'd0 || class_hv_out[2] !== 9'd1)
      begin errors++; $display("FAIL bwf_low_dims got=%0d,%0d,%0d exp=1,0,1", class_hv_out[0], class_hv_out[1], class_hv_out[2]); end
    checks++; if (sample_count !== 16'd1) begin errors++; $display("FAIL bwf_sample_count got=%0d exp=1", sample_count); end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  task automatic test_hold_and_restart();
    bit ok;
    int idx;
    do_start();
    send_beat({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    send_beat('1, 1'b0, 1'b0);
    close_accum();
    push_expected();
    wait_acc(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_acc_valid_timeout got=%b exp=1", acc_valid); end
    e = sb.pop_front();
    for (int c = 0; c < 10; c++) begin
      hv_valid = c[0];
      hv_in    = {32{$urandom}};
      tick();
      idx = first_diff(class_hv_out, e.hv);
      checks++; if (idx >= 0 || acc_valid !== 1'b1) begin errors++; $display("FAIL hold_stable cyc=%0d dim=%0d acc_valid=%b exp=1", c, idx, acc_valid); end
    end
    hv_valid = 1'b0;
    checks++; if (sample_count !== e.cnt) begin errors++; $display("FAIL hold_sample_count got=%0d exp=%0d", sample_count, e.cnt); end
    // Restart from DONE drops the pending result.
    do_start();
    checks++; if (class_hv_out !== '0) begin errors++; $display("FAIL restart_clear dim=%0d not zero", first_diff(class_hv_out, '0)); end
    checks++; if (hv_ready !== 1'b1 || acc_valid !== 1'b0) begin errors++; $display("FAIL restart_state hv_ready=%b acc_valid=%b exp=1,0", hv_ready, acc_valid); end
    checks++; if (sample_count !== '0) begin errors++; $display("FAIL restart_sample_count got=%0d exp=0", sample_count); end
    close_accum();
    push_expected();
    wait_acc(ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_acc_valid_timeout got=%b exp=1", acc_valid); end
    e = sb.pop_front();
    checks++; if (class_hv_out !== e.hv || sample_count !== e.cnt) begin errors++; $display("FAIL empty_result count got=%0d exp=%0d", sample_count, e.cnt); end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

  task automatic test_start_in_accum();
    bit ok;
    int idx;
    logic [D-1:0] v;
    do_start();
    send_beat('1, 1'b0, 1'b0);
    // start with a valid beat: counters re-clear, the beat is dropped.
    start    = 1'b1;
    hv_valid = 1'b1;
    hv_in    = '1;
    tick();
    start    = 1'b0;
    hv_valid = 1'b0;
    model_clear();
    checks++; if (class_hv_out !== '0 || sample_count !== '0) begin errors++; $display("FAIL reclear count got=%0d exp=0", sample_count); end
    v = '0;
    v[D-1] = 1'b1;
    v[7]   = 1'b1;
    send_beat(v, 1'b0, 1'b1);
    push_expected();
    wait_acc(ok);
    checks++; if (!ok) begin errors++; $display("FAIL reclear_acc_valid_timeout got=%b exp=1", acc_valid); end
    e = sb.pop_front();
    idx = first_diff(class_hv_out, e.hv);
    checks++; if (idx >= 0) begin errors++; $display("FAIL reclear_class_hv dim=%0d got=%0d exp=%0d", idx, class_hv_out[idx], e.hv[idx]); end
    checks++; if (sample_count !== e.cnt) begin errors++; $display("FAIL reclear_sample_count got=%0d exp=%0d", sample_count, e.cnt); end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask

`ifdef CLASS_ACC_RETRAIN_EN
  task automatic test_retrain();
    bit ok;
    int idx;
    do_start();
    repeat (2) send_beat('1, 1'b0, 1'b0);
    repeat (3) send_beat('1, 1'b1, 1'b0);
    close_accum();
    push_expected();
    wait_acc(ok);
    checks++; if (!ok) begin errors++; $display("FAIL retrain_acc_valid_timeout got=%b exp=1", acc_valid); end
    e = sb.pop_front();
    idx = first_diff(class_hv_out, e.hv);
    checks++; if (idx >= 0 || class_hv_out !== '0) begin errors++; $display("FAIL retrain_class_hv dim=%0d", idx); end
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL retrain_sat_flag got=%b exp=1", sat_flag); end
    checks++; if (sample_count !== 16'd2) begin errors++; $display("FAIL retrain_sample_count got=%0d exp=2", sample_count); end
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
  endtask
`endif

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    hv_valid  = 1'b0;
    hv_in     = '0;
    finish    = 1'b0;
    acc_ready = 1'b0;
`ifdef CLASS_ACC_RETRAIN_EN
    hv_sub    = 1'b0;
`endif
    model_clear();
    repeat (2) tick();
    rst = 1'b0;

    test_reset();
    test_basic();
    test_saturation();
    test_beat_with_finish();
    test_hold_and_restart();
    test_start_in_accum();
`ifdef CLASS_ACC_RETRAIN_EN
    test_retrain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
